apu_reg_loader: RTL and testbench
=================================

# apu_reg_loader

Serial register loader that configures the eight 8-bit APU control registers from a two-wire serial link (`sck`, `sdi`). The block oversamples the link in the system clock domain, assembles 11-bit frames of 3-bit address and 8-bit data, and writes the addressed register. It also recovers from truncated frames with an idle timeout. It sits between the external host pins and the APU channel logic, which reads `apu_reg_0`..`apu_reg_7` directly.

## Interface
Parameters:
- `TIMEOUT`, default 255: clk cycles without an `sck` rising edge before a partial frame is discarded. Legal range is 3..65535.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sck`  in  1  serial clock, asynchronous to `clk`, idles low.
- `sdi`  in  1  serial data, sampled on `sck` rising edges.
- `apu_reg_0` .. `apu_reg_7`  out  8 each  register bank contents.
- `wr_stb`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  3  address of the last write; holds its value between writes.
- `frame_err`  out  1  one-cycle pulse when a partial frame is discarded by timeout.

## Operation
- **Synchronizers:** `sck` and `sdi` each pass through 2 flops (`s1`, `s2`). A third flop `sck_d` holds the previous `sck_s2`. `rise = sck_s2 & ~sck_d`.
- **Frame format:** 11 bits, MSB first: `a2 a1 a0 d7 .. d0`.
- **State:** 10-bit shift register `shreg`, 4-bit `bit_cnt` (0..10), idle counter `idle_cnt` of width clog2(TIMEOUT+1).
- **On a clock edge with `rise`=1:**
  - `shreg <= {shreg[8:0], sdi_s2}`.
  - `idle_cnt <= 0`.
  - If `bit_cnt` < 10: `bit_cnt++`.
  - If `bit_cnt` == 10: let `frame = {shreg, sdi_s2}`. Then `apu_reg[frame[10:8]] <= frame[7:0]`, `wr_addr <= frame[10:8]`, `wr_stb <= 1`, `bit_cnt <= 0`.
- **On a clock edge with `rise`=0 and `bit_cnt` != 0:**
  - If `idle_cnt` == TIMEOUT-1: `bit_cnt <= 0`, `idle_cnt <= 0`, `frame_err <= 1`.
  - Otherwise `idle_cnt++`.
- **On a clock edge with `rise`=0 and `bit_cnt` == 0:** `idle_cnt` holds at 0.
- `wr_stb` and `frame_err` are 0 on every edge not listed above.
- **Simultaneous `rise` and timeout:** `rise` wins. The bit is accepted, the counter clears, and no `frame_err` is raised.
- **Repeated writes:** writing an address overwrites it. The other seven registers are untouched.
- **No write path except a complete frame.** A discarded partial frame never modifies any register or `wr_addr`.
- **States** (encoded by `bit_cnt`): IDLE (0), SHIFT (1..10).
  - IDLE -> SHIFT on `rise`.
  - SHIFT -> SHIFT on `rise` while `bit_cnt` < 10.
  - SHIFT -> IDLE on the 11th `rise` (write) or on timeout (error).

## Timing
- **Reset** (`rst_n`=0, takes effect immediately, no clock needed) clears:
  - all `apu_reg_*` = 0x00, `wr_addr` = 0, `wr_stb` = 0, `frame_err` = 0;
  - `bit_cnt`, `idle_cnt`, `shreg`, and all synchronizer flops = 0.
- **Reset mid-frame:** the partial frame is lost. Decoding restarts at bit 0 after release.
- **`sck` high at reset release:** this produces one rising edge, which is counted as a bit. Hosts must hold `sck` low through reset.
- **Latency:** a pin-level `sck` rise that meets setup before clk edge k is detected at edge k+2. The register update and `wr_stb` become visible after that edge.
- **Host requirements:**
  - `sck` high ≥ 2 clk periods and low ≥ 2 clk periods.
  - `sdi` stable from 1 clk period before to 3 clk periods after each `sck` rise.
- **Frame rate:** back-to-back frames need no gap. Bit 0 of the next frame may follow the 11th bit with normal `sck` timing.
- **Timeout window:** the gap between successive `rise` detections must be ≤ TIMEOUT clk cycles. A gap of TIMEOUT+1 cycles (TIMEOUT consecutive no-rise edges) triggers the timeout.

## Test plan
- **Reset:** assert `rst_n`=0 mid-simulation with no clock running. All `apu_reg_*`=0x00, `wr_addr`=0, `wr_stb`=0, `frame_err`=0 immediately.
- **Single frame:** send addr=3, data=0xA5 (bits 011_10100101). Expect `apu_reg_3`=0xA5, `wr_addr`=3, exactly one `wr_stb` pulse, all other registers 0x00.
- **Back-to-back frames:** send addr 0 = 0x12, then immediately addr 7 = 0xFF, then addr 0 = 0x34. Expect `apu_reg_0`=0x34, `apu_reg_7`=0xFF, three `wr_stb` pulses, final `wr_addr`=0.
- **Truncated frame:** send 5 bits, then idle for TIMEOUT+5 cycles. Expect exactly one `frame_err` pulse and no register change. Then send addr 1 = 0x3C and expect `apu_reg_1`=0x3C.
- **Timeout boundary** (TIMEOUT=16): inter-bit gap of 16 cycles gives a valid write, no `frame_err`. Gap of 17 cycles gives `frame_err`, and the remaining bits are decoded as a new frame.
- **Reset mid-frame:** reset after 6 bits of an addr-2 frame. Registers stay 0x00. A subsequent full frame addr 2 = 0x5A gives `apu_reg_2`=0x5A.

Source files
------------

// File: rtl/apu_reg_loader.sv
// apu_reg_loader: serial loader for the eight 8-bit APU control registers.
// Oversamples a two-wire link (sck, sdi) in the clk domain, assembles
// 11-bit frames {addr[2:0], data[7:0]} MSB first, and writes the addressed
// register. A partial frame is dropped if sck stops rising for TIMEOUT cycles.
module apu_reg_loader #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sck,
   input  logic       sdi,
   output logic [7:0] apu_reg_0,
   output logic [7:0] apu_reg_1,
   output logic [7:0] apu_reg_2,
   output logic [7:0] apu_reg_3,
   output logic [7:0] apu_reg_4,
   output logic [7:0] apu_reg_5,
   output logic [7:0] apu_reg_6,
   output logic [7:0] apu_reg_7,
   output logic       wr_stb,
   output logic [2:0] wr_addr,
   output logic       frame_err
);

   localparam int              IW        = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0]   IDLE_LAST = IW'(TIMEOUT - 1);
   localparam logic [3:0]      LAST_BIT  = 4'd10;

   // Synchronizer and edge-detect flops
   logic sck_s1, sck_s2, sck_d;
   logic sdi_s1, sdi_s2;

   // Frame assembly state; bit_cnt == 0 is IDLE, 1..10 is SHIFT
   logic [9:0]    shreg;
   logic [3:0]    bit_cnt;
   logic [IW-1:0] idle_cnt;

   logic [7:0]  regs [8];
   logic        rise;
   logic [10:0] frame;

   assign rise  = sck_s2 & ~sck_d;
   assign frame = {shreg, sdi_s2};

   assign apu_reg_0 = regs[0];
   assign apu_reg_1 = regs[1];
   assign apu_reg_2 = regs[2];
   assign apu_reg_3 = regs[3];
   assign apu_reg_4 = regs[4];
   assign apu_reg_5 = regs[5];
   assign apu_reg_6 = regs[6];
   assign apu_reg_7 = regs[7];

   // Bring sck/sdi into the clk domain and keep the previous sck for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_s1 <= 1'b0;
         sck_s2 <= 1'b0;
         sck_d  <= 1'b0;
         sdi_s1 <= 1'b0;
         sdi_s2 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let each flop sample the previous stage's old value, forming a real pipeline.
         sck_s1 <= sck;
         sck_s2 <= sck_s1;
         sck_d  <= sck_s2;
         sdi_s1 <= sdi;
         sdi_s2 <= sdi_s1;
      end
   end

   // Shift in bits on each sck rise, commit on the 11th, drop partial frames on idle timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         idle_cnt  <= '0;
         wr_stb    <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
         // NOTE: the bank is only 64 flops and must read 0x00 right after reset, so it is reset like any other state.
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         wr_stb    <= 1'b0;
         frame_err <= 1'b0;
         if (rise) begin
            // A rise always wins over a coincident timeout
            shreg    <= {shreg[8:0], sdi_s2};
            idle_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
               regs[frame[10:8]] <= frame[7:0];
               wr_addr           <= frame[10:8];
               wr_stb            <= 1'b1;
               bit_cnt           <= '0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != '0) begin
            if (idle_cnt == IDLE_LAST) begin
               bit_cnt   <= '0;
               idle_cnt  <= '0;
               frame_err <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_apu_reg_loader.sv
// tb_apu_reg_loader: drives serial frames at the pin level, predicts the
// resulting writes and timeouts from frame/gap rules, and checks the DUT
// through a scoreboard queue drained by an independent monitor.
module tb_apu_reg_loader;

   localparam int TIMEOUT = 16;

   logic clk = 1'b0, clk_en = 1'b1;
   logic rst_n = 1'b0, sck = 1'b0, sdi = 1'b0;
   logic [7:0] apu_reg_0, apu_reg_1, apu_reg_2, apu_reg_3;
   logic [7:0] apu_reg_4, apu_reg_5, apu_reg_6, apu_reg_7;
   logic       wr_stb, frame_err;
   logic [2:0] wr_addr;

   apu_reg_loader #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi),
      .apu_reg_0(apu_reg_0), .apu_reg_1(apu_reg_1), .apu_reg_2(apu_reg_2), .apu_reg_3(apu_reg_3),
      .apu_reg_4(apu_reg_4), .apu_reg_5(apu_reg_5), .apu_reg_6(apu_reg_6), .apu_reg_7(apu_reg_7),
      .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
   );

   always #5 if (clk_en) clk = ~clk;

   logic [7:0] regs_out [8];
   assign regs_out[0] = apu_reg_0;
   assign regs_out[1] = apu_reg_1;
   assign regs_out[2] = apu_reg_2;
   assign regs_out[3] = apu_reg_3;
   assign regs_out[4] = apu_reg_4;
   assign regs_out[5] = apu_reg_5;
   assign regs_out[6] = apu_reg_6;
   assign regs_out[7] = apu_reg_7;

   typedef enum {EV_WRITE, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [2:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t        expq [$];
   logic [7:0] shadow [8];
   logic [2:0] shadow_addr = '0;
   int         errors = 0, checks = 0;
   int         stb_cnt = 0, err_cnt = 0;
   int         exp_writes = 0, exp_errs = 0;
   longint     cyc = 0;

   // Reference model: pending bits of the frame in progress and time of the last rise
   bit         pend [$];
   longint     last_rise = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_err();
      expq.push_back('{kind: EV_ERR, addr: 3'd0, data: 8'd0});
      exp_errs++;
      pend.delete();
   endtask

   // A rise arriving more than TIMEOUT cycles after the previous one drops the partial frame first
   task automatic model_rise(input bit b);
      logic [10:0] w;
      if (pend.size() > 0 && (cyc - last_rise) > TIMEOUT) push_err();
      pend.push_back(b);
      last_rise = cyc;
      if (pend.size() == 11) begin
         w = '0;
         foreach (pend[i]) w[10-i] = pend[i];
         expq.push_back('{kind: EV_WRITE, addr: w[10:8], data: w[7:0]});
         exp_writes++;
         pend.delete();
      end
   endtask

   // One bit; rise-to-rise spacing equals period when calls are back to back
   task automatic send_bit(input bit b, input int period);
      sdi = b;
      @(negedge clk);
      sck = 1'b1;
      model_rise(b);
      repeat (2) @(negedge clk);
      sck = 1'b0;
      repeat (period - 3) @(negedge clk);
   endtask

   task automatic idle(input int n);
      if (pend.size() > 0 && (cyc + n - last_rise) > TIMEOUT) push_err();
      repeat (n) @(negedge clk);
   endtask

   // Sends bits [10:10-nbits+1] of {addr,data}; send-order bit gap_bit uses period gap
   task automatic send_word(input logic [2:0] addr, input logic [7:0] data, input int period,
                            input int nbits = 11, input int gap_bit = -1, input int gap = 0);
      logic [10:0] w;
      w = {addr, data};
      for (int i = 0; i < nbits; i++)
         send_bit(w[10-i], (i == gap_bit) ? gap : period);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard drained", expq.size(), 0);
   endtask

   // Reset with the clock stopped; outputs must clear without any edge
   task automatic stopped_reset();
      @(negedge clk);
      clk_en = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) check($sformatf("reset apu_reg_%0d", i), regs_out[i], 8'h00);
      check("reset wr_addr", wr_addr, 3'd0);
      check("reset wr_stb", wr_stb, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      pend.delete();
      expq.delete();
      foreach (shadow[i]) shadow[i] = 8'h00;
      shadow_addr = '0;
      #10 rst_n = 1'b1;
      #2 clk_en = 1'b1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops an expectation for every strobe and tracks the bank against a shadow copy
   initial begin
      ev_t ev;
      foreach (shadow[i]) shadow[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (wr_stb || frame_err) begin
               if (wr_stb) stb_cnt++;
               if (frame_err) err_cnt++;
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected event: got wr_stb=%0b frame_err=%0b, expected none (t=%0t)",
                           wr_stb, frame_err, $time);
               end else begin
                  ev = expq.pop_front();
                  check("event kind {wr_stb,frame_err}", {wr_stb, frame_err},
                        (ev.kind == EV_WRITE) ? 2'b10 : 2'b01);
                  if (ev.kind == EV_WRITE) begin
                     shadow[ev.addr] = ev.data;
                     shadow_addr     = ev.addr;
                  end
               end
            end
            for (int i = 0; i < 8; i++) check($sformatf("apu_reg_%0d", i), regs_out[i], shadow[i]);
            check("wr_addr", wr_addr, shadow_addr);
         end
      end
   end

   initial begin
      int s0, e0, nb, p;
      logic [2:0] a;
      logic [7:0] d;

      // Power-on reset
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) check($sformatf("por apu_reg_%0d", i), regs_out[i], 8'h00);
      check("por wr_stb", wr_stb, 1'b0);
      check("por frame_err", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame
      s0 = stb_cnt;
      send_word(3'd3, 8'hA5, 5);
      idle(10);
      drain();
      check("single apu_reg_3", apu_reg_3, 8'hA5);
      check("single wr_addr", wr_addr, 3'd3);
      check("single stb pulses", stb_cnt - s0, 1);
      check("single apu_reg_0 untouched", apu_reg_0, 8'h00);

      // Asynchronous reset with the clock stopped
      stopped_reset();
      check("post-reset apu_reg_3", apu_reg_3, 8'h00);

      // Back-to-back frames
      s0 = stb_cnt;
      send_word(3'd0, 8'h12, 4);
      send_word(3'd7, 8'hFF, 4);
      send_word(3'd0, 8'h34, 4);
      idle(8);
      drain();
      check("b2b apu_reg_0", apu_reg_0, 8'h34);
      check("b2b apu_reg_7", apu_reg_7, 8'hFF);
      check("b2b stb pulses", stb_cnt - s0, 3);
      check("b2b wr_addr", wr_addr, 3'd0);

      // Truncated frame
      s0 = stb_cnt;
      e0 = err_cnt;
      send_word(3'd5, 8'h77, 5, 5);
      idle(TIMEOUT + 5);
      drain();
      check("trunc frame_err pulses", err_cnt - e0, 1);
      check("trunc no write", stb_cnt - s0, 0);
      check("trunc apu_reg_5", apu_reg_5, 8'h00);
      send_word(3'd1, 8'h3C, 5);
      idle(6);
      drain();
      check("after trunc apu_reg_1", apu_reg_1, 8'h3C);

      // Timeout boundary: gap of TIMEOUT is fine, TIMEOUT+1 drops the partial frame
      e0 = err_cnt;
      send_word(3'd5, 8'hC3, 5, 11, 4, TIMEOUT);
      idle(6);
      drain();
      check("gap16 apu_reg_5", apu_reg_5, 8'hC3);
      check("gap16 no frame_err", err_cnt - e0, 0);
      send_word(3'd6, 8'h96, 5, 11, 4, TIMEOUT + 1);
      send_word(3'b101, 8'h50, 5, 5);
      idle(6);
      drain();
      check("gap17 frame_err pulses", err_cnt - e0, 1);
      check("gap17 apu_reg_6 untouched", apu_reg_6, 8'h00);
      check("gap17 realigned apu_reg_2", apu_reg_2, 8'hD5);

      // Reset mid-frame
      send_word(3'd2, 8'hEE, 5, 6);
      stopped_reset();
      check("midreset apu_reg_2", apu_reg_2, 8'h00);
      send_word(3'd2, 8'h5A, 5);
      idle(6);
      drain();
      check("midreset then apu_reg_2", apu_reg_2, 8'h5A);

      // Randomized frames, truncations and long gaps
      for (int k = 0; k < 60; k++) begin
         a  = 3'($urandom_range(0, 7));
         d  = 8'($urandom_range(0, 255));
         nb = ($urandom_range(0, 99) < 15) ? $urandom_range(1, 10) : 11;
         for (int i = 0; i < nb; i++) begin
            p = ($urandom_range(0, 99) < 8) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                            : $urandom_range(4, 8);
            send_bit(bit'(((({a, d}) >> (10 - i)) & 11'd1) != 0), p);
         end
         if (nb < 11) idle(TIMEOUT + 3);
      end

      idle(TIMEOUT + 10);
      drain();
      check("total writes", stb_cnt, exp_writes);
      check("total frame errors", err_cnt, exp_errs);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
